// File: rtl/mm_sched_pkg.sv
// Shared definitions for the MM instruction scheduler.
// Contents: scheduler FSM state type, error codes, instruction field
// bit positions and the buffer-select legality check.
package mm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_t;

  localparam logic [2:0] ERR_NONE          = 3'd0;
  localparam logic [2:0] ERR_IN_SEL        = 3'd1;
  localparam logic [2:0] ERR_OUT_SEL       = 3'd2;
  localparam logic [2:0] ERR_BANK_CONFLICT = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT       = 3'd4;

  localparam int unsigned IN_SEL_LSB  = 1;
  localparam int unsigned IN_SEL_MSB  = 4;
  localparam int unsigned OUT_SEL_LSB = 7;
  localparam int unsigned OUT_SEL_MSB = 10;
  localparam int unsigned ACC_BIT     = 13;
  localparam int unsigned N_LSB       = 110;
  localparam int unsigned N_MSB       = 127;

  // Only banks 2 and 3 may be written by the MM top.
  localparam logic [3:0] OUT_SEL_BANK2 = 4'b0100;
  localparam logic [3:0] OUT_SEL_BANK3 = 4'b1000;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Select-field checks in priority order; returns ERR_NONE when legal.
  function automatic logic [2:0] check_sel(input logic [3:0] in_sel,
                                           input logic [3:0] out_sel);
    if (!is_onehot4(in_sel))
      return ERR_IN_SEL;
    if ((out_sel != OUT_SEL_BANK2) && (out_sel != OUT_SEL_BANK3))
      return ERR_OUT_SEL;
    if (in_sel == out_sel)
      return ERR_BANK_CONFLICT;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mm_inst_fifo.sv
// Synchronous instruction FIFO, DEPTH x W, with full/empty flags.
// Ports: clk, rstn (sync active-low), push/wdata (write side),
//        pop/rdata (read side, rdata shows the head entry combinationally),
//        full, empty.
// Pushes while full and pops while empty are ignored.
module mm_inst_fifo
  import mm_sched_pkg::*;
#(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + (AW+1)'(1);
      if (do_pop)
        rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mm_inst_sched.sv
// Instruction scheduler in front of the matrix-multiply top.
// Queues instructions, validates buffer selects, issues a one-cycle start
// and waits for done under a timeout. mm_inst is loaded only on a queue pop,
// so it stays stable for the whole run (the MM top muxes ports from it).
// Ports: clk, rstn (sync active-low); inst_valid/inst_ready/inst_data
//        (instruction input); mm_inst/mm_start/mm_done (MM top side);
//        busy; inst_cnt (retired count, N=0 skips included);
//        err_valid/err_code/err_clear (sticky first error);
//        perf_busy_cycles (non-IDLE cycle count).
// Optional: define MM_SCHED_PERF_EN to build the perf_busy_cycles counter;
//           otherwise it reads constant 0.
module mm_inst_sched
  import mm_sched_pkg::*;
#(
  parameter int unsigned INST_W    = 128,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [INST_W-1:0] inst_data,
  output logic [INST_W-1:0] mm_inst,
  output logic              mm_start,
  input  logic              mm_done,
  output logic              busy,
  output logic [31:0]       inst_cnt,
  output logic              err_valid,
  output logic [2:0]        err_code,
  input  logic              err_clear,
  output logic [31:0]       perf_busy_cycles
);

  sched_state_t         state;
  sched_state_t         state_nx;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [INST_W-1:0]    fifo_rdata;
  logic                 pop;
  logic                 retire;
  logic                 err_set;
  logic [2:0]           err_new;
  logic                 tmo_clr;
  logic                 tmo_step;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W-1:0] tmo_inc;
  logic [2:0]           sel_err;
  logic                 n_zero;

  mm_inst_fifo #(
    .W     (INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inst_valid && !fifo_full),
    .wdata (inst_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign inst_ready = !fifo_full;
  assign busy       = !fifo_empty || (state != ST_IDLE);

  // mm_inst doubles as the current-instruction register.
  assign sel_err = check_sel(mm_inst[IN_SEL_MSB:IN_SEL_LSB],
                             mm_inst[OUT_SEL_MSB:OUT_SEL_LSB]);
  assign n_zero  = (mm_inst[N_MSB:N_LSB] == '0);
  assign tmo_inc = tmo_cnt + TIMEOUT_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    mm_start = 1'b0;
    retire   = 1'b0;
    err_set  = 1'b0;
    err_new  = ERR_NONE;
    tmo_clr  = 1'b0;
    tmo_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sel_err != ERR_NONE) begin
          err_set  = 1'b1;
          err_new  = sel_err;
          state_nx = ST_IDLE;
        end else if (n_zero) begin
          retire   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mm_start = 1'b1;
        tmo_clr  = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (mm_done) begin
          retire   = 1'b1;
          state_nx = ST_IDLE;
        end else if (tmo_inc == '1) begin
          err_set  = 1'b1;
          err_new  = ERR_TIMEOUT;
          state_nx = ST_IDLE;
        end else begin
          tmo_step = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mm_inst   <= '0;
      tmo_cnt   <= '0;
      inst_cnt  <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (pop)
        mm_inst <= fifo_rdata;
      if (tmo_clr)
        tmo_cnt <= '0;
      else if (tmo_step)
        tmo_cnt <= tmo_inc;
      if (retire)
        inst_cnt <= inst_cnt + 32'd1;
      // Clear wins over a same-cycle error; only the first error is kept.
      if (err_clear) begin
        err_valid <= 1'b0;
        err_code  <= ERR_NONE;
      end else if (err_set && !err_valid) begin
        err_valid <= 1'b1;
        err_code  <= err_new;
      end
    end
  end

`ifdef MM_SCHED_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!rstn)
      perf_cnt <= '0;
    else if ((state != ST_IDLE) && (perf_cnt != '1))
      perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_busy_cycles = perf_cnt;
`else
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mm_inst_sched.sv
module tb_mm_inst_sched;

  logic         clk = 1'b0;
  logic         rstn;
  logic         inst_valid;
  logic         inst_ready;
  logic [127:0] inst_data;
  logic [127:0] mm_inst;
  logic         mm_start;
  logic         mm_done;
  logic         busy;
  logic [31:0]  inst_cnt;
  logic         err_valid;
  logic [2:0]   err_code;
  logic         err_clear;
  logic [31:0]  perf_busy_cycles;

  always #5 clk = ~clk;

  mm_inst_sched #(
    .INST_W    (128),
    .DEPTH     (4),
    .TIMEOUT_W (4)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .mm_inst          (mm_inst),
    .mm_start         (mm_start),
    .mm_done          (mm_done),
    .busy             (busy),
    .inst_cnt         (inst_cnt),
    .err_valid        (err_valid),
    .err_code         (err_code),
    .err_clear        (err_clear),
    .perf_busy_cycles (perf_busy_cycles)
  );

`ifdef MM_SCHED_PERF_EN
  localparam int PERF_ONE_RUN = 13;
`else
  localparam int PERF_ONE_RUN = 0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cd    = 0;          // cycles until the responder raises mm_done
  int resp_mode = 0;      // 0: none, 1: fixed delay, 2: random incl. timeouts
  int done_delay = 2;
  logic [127:0] started_q[$];
  bit           to_q[$];  // per start in mode 2: 1 = done withheld

  typedef struct {
    logic [127:0] inst;
    logic [2:0]   err;
    bit           start;
    bit           cnt;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Advance one cycle; act as the MM top responding to mm_start.
  task automatic step();
    int d;
    @(posedge clk);
    #1;
    cyc++;
    mm_done = 1'b0;
    if (mm_start) begin
      started_q.push_back(mm_inst);
      if (resp_mode == 1) cd = done_delay;
      else if (resp_mode == 2) begin
        d = $urandom_range(0, 6);
        to_q.push_back(d == 0);
        if (d != 0) cd = d;
      end
    end else if (cd > 0) begin
      chk("inst_stable_run", mm_inst, started_q[$]);
      cd--;
      if (cd == 0) mm_done = 1'b1;
    end
  endtask

  task automatic push(input logic [127:0] w);
    int n = 0;
    while (!inst_ready && n < 200) begin step(); n++; end
    if (!inst_ready) expired("push_ready");
    inst_valid = 1'b1;
    inst_data  = w;
    step();
    inst_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while ((busy || cd > 0) && n < maxc) begin step(); n++; end
    if (busy || cd > 0) expired(name);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!mm_start && n < 20) begin step(); n++; end
    if (!mm_start) expired(name);
  endtask

  task automatic do_reset();
    rstn = 1'b0; inst_valid = 1'b0; mm_done = 1'b0; err_clear = 1'b0;
    step();
    step();
    rstn = 1'b1;
    cd = 0;
    started_q.delete();
    to_q.delete();
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  function automatic logic [127:0] mk(input logic [3:0] in_s, input logic [3:0] out_s,
                                      input logic acc, input logic [17:0] n);
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    w[4:1]     = in_s;
    w[10:7]    = out_s;
    w[13]      = acc;
    w[127:110] = n;
    return w;
  endfunction

  function automatic logic [127:0] rand_inst();
    logic [3:0]  i;
    logic [3:0]  o;
    logic [17:0] n;
    i = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'(1 << $urandom_range(0, 3));
    o = ($urandom_range(0, 3) == 0) ? 4'($urandom()) :
        (($urandom_range(0, 1) == 1) ? 4'b0100 : 4'b1000);
    n = ($urandom_range(0, 3) == 0) ? 18'd0 : 18'($urandom());
    return mk(i, o, 1'($urandom()), n);
  endfunction

  // Reference outcome: 1/2/3 select errors, 5 = N==0 skip, 0 = runs.
  function automatic int classify(input logic [127:0] w);
    logic [3:0] i;
    logic [3:0] o;
    i = w[4:1];
    o = w[10:7];
    if ($countones(i) != 1) return 1;
    if (o != 4'd4 && o != 4'd8) return 2;
    if (i == o) return 3;
    if (w[127:110] == 18'd0) return 5;
    return 0;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] fill[5];
    logic [127:0] pushed[$];
    int base;
    int s;
    int c0;
    int n0;
    int exp_err;
    int exp_cnt;
    int j;
    int c;

    vecs[0]  = '{mk(4'b0001, 4'b0100, 1'b0, 18'd5),     3'd0, 1'b1, 1'b1};
    vecs[1]  = '{mk(4'b0010, 4'b1000, 1'b1, 18'd1),     3'd0, 1'b1, 1'b1};
    vecs[2]  = '{mk(4'b1000, 4'b0100, 1'b0, 18'h3ffff), 3'd0, 1'b1, 1'b1};
    vecs[3]  = '{mk(4'b0011, 4'b0100, 1'b0, 18'd4),     3'd1, 1'b0, 1'b0};
    vecs[4]  = '{mk(4'b0000, 4'b0100, 1'b0, 18'd4),     3'd1, 1'b0, 1'b0};
    vecs[5]  = '{mk(4'b0011, 4'b0000, 1'b0, 18'd4),     3'd1, 1'b0, 1'b0};
    vecs[6]  = '{mk(4'b0001, 4'b0010, 1'b0, 18'd4),     3'd2, 1'b0, 1'b0};
    vecs[7]  = '{mk(4'b0001, 4'b1100, 1'b0, 18'd4),     3'd2, 1'b0, 1'b0};
    vecs[8]  = '{mk(4'b0001, 4'b0001, 1'b0, 18'd4),     3'd2, 1'b0, 1'b0};
    vecs[9]  = '{mk(4'b0100, 4'b0100, 1'b0, 18'd4),     3'd3, 1'b0, 1'b0};
    vecs[10] = '{mk(4'b1000, 4'b1000, 1'b1, 18'd4),     3'd3, 1'b0, 1'b0};
    vecs[11] = '{mk(4'b0100, 4'b1000, 1'b1, 18'd0),     3'd0, 1'b0, 1'b1};

    rstn = 1'b0; inst_valid = 1'b0; inst_data = '0; mm_done = 1'b0; err_clear = 1'b0;

    // Reset state
    do_reset();
    chk("rst_mm_inst", mm_inst, 128'd0);
    chk("rst_start", mm_start, 1'b0);
    chk("rst_ready", inst_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", inst_cnt, 32'd0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_err_code", err_code, 3'd0);
    chk("rst_perf", perf_busy_cycles, 32'd0);

    // Single instruction: start at cycle 3, done on the 11th WAIT cycle
    resp_mode = 0;
    a = mk(4'b0001, 4'b0100, 1'b0, 18'd16);
    base = cyc;
    push(a);
    while (cyc - base < 16) begin
      chk("single_start", mm_start, (cyc - base) == 3);
      if (cyc - base >= 2 && cyc - base <= 14) chk("single_inst_stable", mm_inst, a);
      if (cyc - base == 14) chk("single_busy_at_done", busy, 1'b1);
      if (cyc - base == 15) begin
        chk("single_busy_after", busy, 1'b0);
        chk("single_cnt", inst_cnt, 32'd1);
        chk("single_perf", perf_busy_cycles, 32'(PERF_ONE_RUN));
      end
      step();
      if (cyc - base == 14) mm_done = 1'b1;
    end

    // Queue fill: 5 back-to-back pushes while the first run waits
    do_reset();
    resp_mode = 0;
    for (int i = 0; i < 5; i++) begin
      fill[i] = mk(4'(1 << (i % 2)), 4'b1000, 1'b0, 18'(i + 1));
      push(fill[i]);
      chk("fill_ready", inst_ready, i < 4);
    end
    mm_done = 1'b1;
    resp_mode = 1;
    done_delay = 2;
    step();
    wait_idle("fill_drain", 300);
    chk("fill_nstarts", started_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < started_q.size()) chk("fill_order", started_q[i], fill[i]);
    chk("fill_cnt", inst_cnt, 32'd5);

    // Table-driven select / N checks
    resp_mode = 1;
    done_delay = 3;
    for (int i = 0; i < 12; i++) begin
      clear_err();
      c0 = inst_cnt;
      n0 = started_q.size();
      push(vecs[i].inst);
      wait_idle("vec_idle", 100);
      chk("vec_err_code", err_code, vecs[i].err);
      chk("vec_err_valid", err_valid, vecs[i].err != 3'd0);
      chk("vec_start", started_q.size() - n0, vecs[i].start);
      chk("vec_cnt", inst_cnt - 32'(c0), vecs[i].cnt);
    end

    // First error kept, clear then re-record, clear beats same-cycle error
    clear_err();
    n0 = started_q.size();
    push(mk(4'b0011, 4'b0100, 1'b0, 18'd9));
    wait_idle("fe1_idle", 50);
    chk("fe_first", err_code, 3'd1);
    b = mk(4'b0100, 4'b0100, 1'b0, 18'd9);
    push(b);
    wait_idle("fe2_idle", 50);
    chk("fe_kept", err_code, 3'd1);
    chk("fe_no_start", started_q.size(), n0);
    clear_err();
    push(b);
    wait_idle("fe3_idle", 50);
    chk("fe_after_clear", err_code, 3'd3);
    clear_err();
    push(b);
    step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    wait_idle("fe4_idle", 50);
    chk("clear_priority_valid", err_valid, 1'b0);
    chk("clear_priority_code", err_code, 3'd0);

    // N=0 skip followed by a normal instruction
    c0 = inst_cnt;
    n0 = started_q.size();
    a = mk(4'b0010, 4'b0100, 1'b0, 18'd0);
    b = mk(4'b0001, 4'b1000, 1'b1, 18'd33);
    push(a);
    push(b);
    wait_idle("zero_idle", 100);
    chk("zero_nstarts", started_q.size() - n0, 1);
    chk("zero_next_inst", started_q[$], b);
    chk("zero_cnt", inst_cnt - 32'(c0), 2);

    // Timeout: 15 WAIT cycles without done, late done ignored
    resp_mode = 0;
    clear_err();
    c0 = inst_cnt;
    push(mk(4'b1000, 4'b0100, 1'b0, 18'd2));
    wait_start("tmo_start");
    s = cyc;
    while (cyc < s + 15) step();
    chk("tmo_not_yet", err_valid, 1'b0);
    chk("tmo_busy_wait", busy, 1'b1);
    step();
    chk("tmo_err_valid", err_valid, 1'b1);
    chk("tmo_err_code", err_code, 3'd4);
    chk("tmo_idle", busy, 1'b0);
    mm_done = 1'b1;
    step();
    step();
    chk("tmo_late_done_cnt", inst_cnt, 32'(c0));
    chk("tmo_late_done_busy", busy, 1'b0);

    // Randomized traffic against the transaction-level model
    do_reset();
    resp_mode = 2;
    pushed.delete();
    for (int i = 0; i < 40; i++) begin
      a = rand_inst();
      pushed.push_back(a);
      push(a);
      for (int k = $urandom_range(0, 3); k > 0; k--) step();
    end
    wait_idle("rand_idle", 3000);
    exp_err = 0;
    exp_cnt = 0;
    j = 0;
    foreach (pushed[i]) begin
      c = classify(pushed[i]);
      if (c >= 1 && c <= 3) begin
        if (exp_err == 0) exp_err = c;
      end else if (c == 5) begin
        exp_cnt++;
      end else begin
        if (j < started_q.size()) chk("rand_start_inst", started_q[j], pushed[i]);
        if (j < to_q.size() && to_q[j]) begin
          if (exp_err == 0) exp_err = 4;
        end else begin
          exp_cnt++;
        end
        j++;
      end
    end
    chk("rand_nstarts", started_q.size(), j);
    chk("rand_cnt", inst_cnt, 32'(exp_cnt));
    chk("rand_err_code", err_code, 3'(exp_err));
    chk("rand_err_valid", err_valid, exp_err != 0);

    // Reset during WAIT with a second entry still queued
    resp_mode = 0;
    push(mk(4'b0001, 4'b0100, 1'b0, 18'd7));
    push(mk(4'b0010, 4'b1000, 1'b0, 18'd7));
    wait_start("rw_start");
    step();
    step();
    rstn = 1'b0;
    step();
    chk("rw_mm_inst", mm_inst, 128'd0);
    chk("rw_start", mm_start, 1'b0);
    chk("rw_ready", inst_ready, 1'b1);
    chk("rw_busy", busy, 1'b0);
    chk("rw_cnt", inst_cnt, 32'd0);
    chk("rw_err_valid", err_valid, 1'b0);
    chk("rw_err_code", err_code, 3'd0);
    chk("rw_perf", perf_busy_cycles, 32'd0);
    rstn = 1'b1;
    n0 = started_q.size();
    mm_done = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rw_queue_empty", started_q.size(), n0);
    chk("rw_late_done_cnt", inst_cnt, 32'd0);
    chk("rw_busy_after", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
